// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, PC, IR, register file and unified memory.
// Latency: 2-5 cycles per instruction with mem_ready high; retired/illegal are registered.
// Backpressure: holds in FETCH, MEMREAD and MEMWRITE until mem_ready; no other state stalls.
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                RegWrite,
    output logic [2:0]          ImmSrc,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, LUI, JAL, ALUWB, BRANCH
    } state_t;

    state_t state, state_nxt;
    logic   op_known;
    logic   retire_evt;

    // Opcodes this core can execute; anything else is flagged in DECODE.
    always_comb begin
        op_known = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_I) ||
                   (op == OP_JAL)  || (op == OP_BR)    || (op == OP_LUI);
    end

    // An instruction completes on the edge leaving its last state.
    always_comb begin
        retire_evt = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                     ((state == MEMWRITE) && mem_ready);
    end

    // State register, illegal-opcode pulse and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            illegal <= (state == DECODE) && !op_known;
            if (retire_evt)
                retired <= retired + RETIRE_W'(1);
        end
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        unique case (op)
            OP_STORE: ImmSrc = 3'b001;
            OP_BR:    ImmSrc = 3'b010;
            OP_JAL:   ImmSrc = 3'b011;
            OP_LUI:   ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    // Next-state and Moore datapath controls; write enables are killed while reset is high.
    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready)
                    state_nxt = DECODE;
            end
            DECODE: begin
                // Precompute branch/jal target from OldPC + imm into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_R:              state_nxt = EXECR;
                    OP_I:              state_nxt = EXECI;
                    OP_JAL:            state_nxt = JAL;
                    OP_BR:             state_nxt = BRANCH;
                    OP_LUI:            state_nxt = LUI;
                    default:           state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                state_nxt = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready)
                    state_nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready)
                    state_nxt = FETCH;
            end
            EXECR: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b10;
                state_nxt = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUOp     = 2'b10;
                state_nxt = ALUWB;
            end
            LUI: begin
                ALUSrcA   = 2'b11;
                ALUSrcB   = 2'b01;
                state_nxt = ALUWB;
            end
            JAL: begin
                // PC takes the target from ALUOut while ALU forms OldPC + 4 for rd.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                PCWrite   = 1'b1;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                // Unknown funct3 values are simply not taken.
                if (funct3 == 3'b000)
                    PCWrite = zero;
                else if (funct3 == 3'b001)
                    PCWrite = !zero;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    op;
    logic [2:0]    funct3;
    logic          zero;
    logic          mem_ready;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0]    ImmSrc;
    logic [RW-1:0] retired;

    multicycle_controller #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic       rw;
    } ctl_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [RW-1:0] m_ret = '0;
    logic          m_ill = 1'b0;
    logic [6:0]    cur_op = 7'b0110011;
    logic [2:0]    cur_f3 = 3'b000;
    logic          cur_z  = 1'b0;

    function automatic ctl_t c(input logic pcw, input logic adr, input logic mw, input logic irw,
                               input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] aop, input logic rw);
        ctl_t r;
        r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw; r.rs = rs;
        r.sa = sa; r.sb = sb; r.aop = aop; r.rw = rw;
        return r;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        if (o == 7'b0110111) return 3'b100;
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check every output, advance the model.
    task automatic step(input logic rst, input logic mr, input ctl_t e,
                        input logic ret, input logic ill_next);
        @(negedge clk);
        reset     = rst;
        mem_ready = mr;
        op        = cur_op;
        funct3    = cur_f3;
        zero      = cur_z;
        #1;
        chk("PCWrite",   32'(PCWrite),   32'(e.pcw));
        chk("AdrSrc",    32'(AdrSrc),    32'(e.adr));
        chk("MemWrite",  32'(MemWrite),  32'(e.mw));
        chk("IRWrite",   32'(IRWrite),   32'(e.irw));
        chk("ResultSrc", 32'(ResultSrc), 32'(e.rs));
        chk("ALUSrcA",   32'(ALUSrcA),   32'(e.sa));
        chk("ALUSrcB",   32'(ALUSrcB),   32'(e.sb));
        chk("ALUOp",     32'(ALUOp),     32'(e.aop));
        chk("RegWrite",  32'(RegWrite),  32'(e.rw));
        chk("ImmSrc",    32'(ImmSrc),    32'(imm_of(cur_op)));
        chk("illegal",   32'(illegal),   32'(m_ill));
        chk("retired",   32'(retired),   32'(m_ret));
        @(posedge clk);
        if (rst) begin
            m_ret = '0;
            m_ill = 1'b0;
        end else begin
            if (ret) m_ret = m_ret + 1'b1;
            m_ill = ill_next;
        end
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic fetch_phase(input int stall);
        for (int i = 0; i < stall; i++)
            step(1'b0, 1'b0, c(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0, 1'b0);
        step(1'b0, 1'b1, c(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0), 1'b0, 1'b0);
    endtask

    // Up to and including the first MEMWRITE stall cycles; leaves completion to the caller.
    task automatic store_prefix(input int fstall, input int mstall);
        fetch_phase(fstall);
        step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b0, 1'b0);
        step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), 1'b0, 1'b0);
        for (int i = 0; i < mstall; i++)
            step(1'b0, 1'b0, c(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 1'b0);
    endtask

    // Whole instruction expressed as the sequence of phases the ISA rules imply.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input int fstall, input int mstall);
        logic taken;
        cur_op = o; cur_f3 = f3; cur_z = z;
        if (o == 7'b0100011) begin
            store_prefix(fstall, mstall);
            step(1'b0, 1'b1, c(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b1, 1'b0);
            return;
        end
        fetch_phase(fstall);
        case (o)
            7'b0000011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011, 7'b0110111:
                step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b0, 1'b0);
            default: begin
                step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b0, 1'b1);
                return;
            end
        endcase
        case (o)
            7'b0000011: begin
                step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), 1'b0, 1'b0);
                for (int i = 0; i < mstall; i++)
                    step(1'b0, 1'b0, c(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 1'b0);
                step(1'b0, 1'b1, c(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 1'b0);
                step(1'b0, rnd(), c(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1), 1'b1, 1'b0);
            end
            7'b1100011: begin
                taken = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0);
                step(1'b0, rnd(), c(taken,0,0,0,2'b00,2'b10,2'b00,2'b01,0), 1'b1, 1'b0);
            end
            default: begin
                if (o == 7'b0110011)
                    step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0), 1'b0, 1'b0);
                else if (o == 7'b0010011)
                    step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b10,2'b01,2'b10,0), 1'b0, 1'b0);
                else if (o == 7'b0110111)
                    step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b11,2'b01,2'b00,0), 1'b0, 1'b0);
                else
                    step(1'b0, rnd(), c(1,0,0,0,2'b00,2'b01,2'b10,2'b00,0), 1'b0, 1'b0);
                step(1'b0, rnd(), c(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), 1'b1, 1'b0);
            end
        endcase
    endtask

    logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                             7'b1100011, 7'b0110111, 7'b1111111, 7'b0000000, 7'b0010111,
                             7'b1100111};

    initial begin
        reset = 1'b1; mem_ready = 1'b0; op = 7'b0110011; funct3 = 3'b000; zero = 1'b0;
        @(posedge clk);
        // Reset from FETCH with mem_ready high: write enables stay low.
        step(1'b1, 1'b1, c(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0, 1'b0);
        step(1'b1, 1'b1, c(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0, 1'b0);

        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0);   // add x3,x1,x2
        run_instr(7'b0000011, 3'b010, 1'b0, 3, 2);   // lw with stalls, 10 cycles
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 2);   // sw, MemWrite 3 cycles
        run_instr(7'b1100011, 3'b000, 1'b1, 0, 0);   // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0);   // beq not taken
        run_instr(7'b1100011, 3'b001, 1'b0, 0, 0);   // bne taken
        run_instr(7'b1100011, 3'b101, 1'b1, 0, 0);   // other funct3: not taken
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);   // illegal
        run_instr(7'b0110111, 3'b000, 1'b0, 1, 0);   // lui after illegal
        run_instr(7'b1101111, 3'b000, 1'b0, 0, 0);   // jal
        run_instr(7'b0010011, 3'b000, 1'b0, 0, 0);   // addi

        // Reset in a MEMWRITE stall: store is killed, counter clears, next is FETCH.
        cur_op = 7'b0100011; cur_f3 = 3'b010; cur_z = 1'b0;
        store_prefix(1, 2);
        step(1'b1, 1'b0, c(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b0, 2, 0);

        for (int n = 0; n < 300; n++)
            run_instr(ops[$urandom_range(0, 10)], 3'($urandom_range(0, 3)), rnd(),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, PC, instruction register, register file and the unified instruction/data memory.
- Issues the 2-bit ALU operation class consumed by the ALU decoder, which also receives op[5], funct3 and funct7b5.
- Stalls on a memory-ready handshake.
- Supports lw, sw, R-type, I-type ALU, jal, beq/bne and lui; flags illegal opcodes.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction opcode field from the instruction register
- funct3  in  3  instruction funct3 field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result
- ALUSrcA  out  2  ALU operand A: 00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  ALU operand B: 00 rs2, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 subtract, 10 decode from funct fields
- RegWrite  out  1  register-file write enable
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  RETIRE_W  count of completed instructions

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - state <= FETCH; retired <= 0; illegal <= 0.
  - While reset = 1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - The first cycle after reset deasserts is FETCH.
- Output style: Moore outputs from the state, except where gating by mem_ready, zero or funct3 is listed. Any field not listed for a state is 0.
- ImmSrc is combinational from op in every state:
  - 0000011 / 0010011 -> 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 1101111 -> 011
  - 0110111 -> 100
  - otherwise 000
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite = PCWrite = mem_ready. Go to DECODE when mem_ready = 1, else hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - 0110111 -> LUI
    - any other op -> FETCH, with illegal = 1 during the following cycle only; retired is not incremented.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5] = 0 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle until mem_ready, then -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00 -> ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00 -> FETCH.
    - PCWrite = zero when funct3 = 000 (beq).
    - PCWrite = ~zero when funct3 = 001 (bne).
    - PCWrite = 0 for any other funct3 (treated as not taken, not illegal).
- Retire counter: increments by 1 on the clock edge leaving MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH. Wraps to 0 past all-ones.
- Cycle counts with mem_ready tied high:
  - lw = 5
  - sw = 4
  - R / I / lui / jal = 4
  - branch = 3
  - illegal = 2
- Reset asserted mid-instruction, including during a stall: the next state is FETCH, no write enable is asserted in the reset cycle, and retired clears.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset, then mem_ready = 1 with IR = 0x002081B3 (add x3,x1,x2):
  - states FETCH, DECODE, EXECR, ALUWB;
  - ALUOp = 10 in EXECR; RegWrite = 1 only in cycle 4;
  - retired = 1.
- lw x3,0(x1) (0x0000A183) with mem_ready held low for 3 cycles in FETCH and 2 cycles in MEMREAD:
  - IRWrite and PCWrite pulse exactly once;
  - AdrSrc = 1 during MEMREAD;
  - RegWrite with ResultSrc = 01 in MEMWB; total 10 cycles.
- sw (op 0100011) with a mem_ready stall of 2 cycles:
  - MemWrite high for 3 consecutive cycles;
  - RegWrite never asserted; retired increments once.
- beq (funct3 000) with zero = 1 -> PCWrite = 1 in BRANCH; repeat with zero = 0 -> PCWrite = 0; bne (funct3 001) with zero = 0 -> PCWrite = 1.
- op = 1111111 -> DECODE returns to FETCH, illegal pulses for exactly 1 cycle, retired unchanged.
- Reset asserted during a MEMWRITE stall:
  - MemWrite = 0 in the reset cycle; retired = 0;
  - next cycle is FETCH with IRWrite following mem_ready.
